// File: rtl/qbus_dma_master_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qbus_dma_master_pkg : state encoding, bus output bundle, QBUS timing defaults
// Revision 1.0
// ----------------------------------------------------------------------------
package qbus_dma_master_pkg;

  localparam int unsigned DEF_ADDR_SETUP  = 3;
  localparam int unsigned DEF_DATA_SETUP  = 2;
  localparam int unsigned DEF_NXM_TIMEOUT = 200;
  localparam int unsigned DEF_MAX_XFERS   = 4;
  localparam int unsigned TMR_W           = 16;
  localparam int unsigned XFER_W          = 4;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_REQ   = 4'd1,
    ST_GRANT = 4'd2,
    ST_ADDR  = 4'd3,
    ST_SYNC  = 4'd4,
    ST_DSET  = 4'd5,
    ST_DIN   = 4'd6,
    ST_DOUT  = 4'd7,
    ST_END   = 4'd8,
    ST_REL   = 4'd9
  } dma_state_t;

  typedef struct packed {
    logic tdmr;
    logic tsack;
    logic bus_master;
    logic tsync;
    logic tdin;
    logic tdout;
    logic twtbt;
    logic addr_oe;
    logic data_oe;
  } bus_out_t;

  // Bus strobes are a pure function of the state being entered, so registering
  // this decode gives glitch-free outputs aligned with the state register.
  function automatic bus_out_t state_outputs(input dma_state_t st, input logic dato);
    bus_out_t o;
    o = '0;
    case (st)
      ST_REQ:   o.tdmr = 1'b1;
      ST_GRANT: o.tsack = 1'b1;
      ST_ADDR: begin
        o.tsack = 1'b1; o.bus_master = 1'b1; o.addr_oe = 1'b1; o.twtbt = dato;
      end
      ST_SYNC: begin
        o.tsack = 1'b1; o.bus_master = 1'b1; o.tsync = 1'b1; o.addr_oe = 1'b1; o.twtbt = dato;
      end
      ST_DSET: begin
        o.tsack = 1'b1; o.bus_master = 1'b1; o.tsync = 1'b1; o.data_oe = 1'b1;
      end
      ST_DIN: begin
        o.tsack = 1'b1; o.bus_master = 1'b1; o.tsync = 1'b1; o.tdin = 1'b1;
      end
      ST_DOUT: begin
        o.tsack = 1'b1; o.bus_master = 1'b1; o.tsync = 1'b1; o.tdout = 1'b1; o.data_oe = 1'b1;
      end
      ST_END: begin
        o.tsack = 1'b1; o.bus_master = 1'b1; o.tsync = 1'b1; o.data_oe = dato;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qbus_dma_master_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qbus_dma_master_arb : DMG daisy-chain pass-through and grant capture
// Revision 1.0
// ----------------------------------------------------------------------------
module qbus_dma_master_arb
  import qbus_dma_master_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic rinit,
  input  logic in_idle,
  input  logic in_req,
  input  logic req,
  input  logic dmgi,
  output logic dmgo,
  output logic grant
);

  logic dmgo_d;

  // A grant already flowing downstream is never stolen: it is held until
  // DMGI drops, and only a fresh DMGI is taken as ours.
  always_comb begin
    dmgo_d = 1'b0;
    if (in_idle && !req) begin
      dmgo_d = dmgi;
    end else if (in_idle || in_req) begin
      dmgo_d = dmgo & dmgi;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || rinit) begin
      dmgo <= 1'b0;
    end else begin
      dmgo <= dmgo_d;
    end
  end

  assign grant = in_req & req & dmgi & ~dmgo;

endmodule
`default_nettype wire

// File: rtl/qbus_dma_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qbus_dma_master : QBUS DMA bus master (arbitration, DATI/DATO, NXM timeout)
// Revision 1.0
// ----------------------------------------------------------------------------
module qbus_dma_master
  import qbus_dma_master_pkg::*;
#(
  parameter int unsigned ADDR_SETUP  = DEF_ADDR_SETUP,
  parameter int unsigned DATA_SETUP  = DEF_DATA_SETUP,
  parameter int unsigned NXM_TIMEOUT = DEF_NXM_TIMEOUT,
  parameter int unsigned MAX_XFERS   = DEF_MAX_XFERS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic RINIT,
  input  logic dma_read_req,
  input  logic dma_write_req,
  output logic dma_bus_master,
  output logic dma_complete,
  output logic dma_nxm,
  output logic TDMR,
  input  logic RDMGI,
  output logic TDMGO,
  output logic TSACK,
  input  logic RSYNC,
  input  logic RRPLY,
  output logic TSYNC,
  output logic TDIN,
  output logic TDOUT,
  output logic TWTBT,
  output logic addr_oe,
  output logic data_oe
);

  localparam logic [TMR_W-1:0]  ADDR_LAST = TMR_W'(ADDR_SETUP - 1);
  localparam logic [TMR_W-1:0]  DATA_LAST = TMR_W'(DATA_SETUP - 1);
  localparam logic [TMR_W-1:0]  NXM_LAST  = TMR_W'(NXM_TIMEOUT - 1);
  localparam logic [XFER_W-1:0] XFER_MAX  = XFER_W'(MAX_XFERS);

  dma_state_t        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d, tmr_inc;
  logic [XFER_W-1:0] xfers_q, xfers_d, xfers_inc;
  logic              dato_q, dato_d;
  logic              complete_d, nxm_d;
  logic              any_req, want_dato, grant;
  bus_out_t          bus_q, bus_d;

  assign any_req   = dma_read_req | dma_write_req;
  assign want_dato = dma_write_req & ~dma_read_req;
  assign tmr_inc   = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
  assign xfers_inc = (xfers_q == '1) ? xfers_q : xfers_q + 1'b1;

  qbus_dma_master_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .rinit   (RINIT),
    .in_idle (state_q == ST_IDLE),
    .in_req  (state_q == ST_REQ),
    .req     (any_req),
    .dmgi    (RDMGI),
    .dmgo    (TDMGO),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (!reset_n || RINIT) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      xfers_q      <= '0;
      dato_q       <= 1'b0;
      bus_q        <= '0;
      dma_complete <= 1'b0;
      dma_nxm      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      xfers_q      <= xfers_d;
      dato_q       <= dato_d;
      bus_q        <= bus_d;
      dma_complete <= complete_d;
      dma_nxm      <= nxm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    xfers_d    = xfers_q;
    dato_d     = dato_q;
    complete_d = 1'b0;
    nxm_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: if (any_req) state_d = ST_REQ;
      ST_REQ: begin
        if (!any_req)   state_d = ST_IDLE;
        else if (grant) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (!any_req) begin
          state_d = ST_REL;
        end else if (!RSYNC && !RRPLY) begin
          state_d = ST_ADDR;
          tmr_d   = '0;
          dato_d  = want_dato;
        end
      end
      ST_ADDR: begin
        tmr_d = tmr_inc;
        if (tmr_q >= ADDR_LAST) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        tmr_d   = '0;
        state_d = dato_q ? ST_DSET : ST_DIN;
      end
      ST_DSET: begin
        tmr_d = tmr_inc;
        if (tmr_q >= DATA_LAST) begin
          state_d = ST_DOUT;
          tmr_d   = '0;
        end
      end
      // A reply on the final timeout cycle still wins over the abort.
      ST_DIN, ST_DOUT: begin
        tmr_d = tmr_inc;
        if (RRPLY) begin
          state_d    = ST_END;
          complete_d = 1'b1;
        end else if (tmr_q >= NXM_LAST) begin
          state_d = ST_REL;
          nxm_d   = 1'b1;
        end
      end
      ST_END: begin
        if (!RRPLY) begin
          xfers_d = xfers_inc;
          if (any_req && (xfers_inc < XFER_MAX)) begin
            state_d = ST_ADDR;
            tmr_d   = '0;
            dato_d  = want_dato;
          end else begin
            state_d = ST_REL;
          end
        end
      end
      ST_REL: begin
        xfers_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    bus_d = state_outputs(state_d, dato_d);
  end

  assign TDMR           = bus_q.tdmr;
  assign TSACK          = bus_q.tsack;
  assign dma_bus_master = bus_q.bus_master;
  assign TSYNC          = bus_q.tsync;
  assign TDIN           = bus_q.tdin;
  assign TDOUT          = bus_q.tdout;
  assign TWTBT          = bus_q.twtbt;
  assign addr_oe        = bus_q.addr_oe;
  assign data_oe        = bus_q.data_oe;

endmodule
`default_nettype wire

// File: tb/tb_qbus_dma_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_qbus_dma_master : vector table, directed corner cases, randomized bursts
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_qbus_dma_master;

  localparam int ADDR_SETUP  = 3;
  localparam int DATA_SETUP  = 2;
  localparam int NXM_TIMEOUT = 200;
  localparam int MAX_XFERS   = 4;
  localparam int NVEC        = 16;

  logic clk = 1'b0;
  logic reset_n, RINIT, dma_read_req, dma_write_req, RDMGI, RSYNC, RRPLY;
  logic dma_bus_master, dma_complete, dma_nxm, TDMR, TDMGO, TSACK;
  logic TSYNC, TDIN, TDOUT, TWTBT, addr_oe, data_oe;

  int checks   = 0;
  int failures = 0;

  always #25 clk = ~clk;

  qbus_dma_master #(
    .ADDR_SETUP  (ADDR_SETUP),
    .DATA_SETUP  (DATA_SETUP),
    .NXM_TIMEOUT (NXM_TIMEOUT),
    .MAX_XFERS   (MAX_XFERS)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .RINIT          (RINIT),
    .dma_read_req   (dma_read_req),
    .dma_write_req  (dma_write_req),
    .dma_bus_master (dma_bus_master),
    .dma_complete   (dma_complete),
    .dma_nxm        (dma_nxm),
    .TDMR           (TDMR),
    .RDMGI          (RDMGI),
    .TDMGO          (TDMGO),
    .TSACK          (TSACK),
    .RSYNC          (RSYNC),
    .RRPLY          (RRPLY),
    .TSYNC          (TSYNC),
    .TDIN           (TDIN),
    .TDOUT          (TDOUT),
    .TWTBT          (TWTBT),
    .addr_oe        (addr_oe),
    .data_oe        (data_oe)
  );

  // {TDMR,TDMGO,TSACK,addr_oe,bus_master,TSYNC,TDIN,TDOUT,data_oe,complete,nxm}
  function automatic logic [10:0] outs();
    return {TDMR, TDMGO, TSACK, addr_oe, dma_bus_master, TSYNC,
            TDIN, TDOUT, data_oe, dma_complete, dma_nxm};
  endfunction

  typedef struct {
    logic [6:0]  in;   // {reset_n,RINIT,read_req,write_req,RDMGI,RSYNC,RRPLY}
    logic [10:0] exp;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; RINIT = 1'b0; dma_read_req = 1'b0; dma_write_req = 1'b0;
    RDMGI = 1'b0; RSYNC = 1'b0; RRPLY = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  // Request a DATI, play arbiter, return once TDIN is seen.
  task automatic grab_din(output bit ok);
    dma_read_req = 1'b1; dma_write_req = 1'b0; ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      step();
      if (TSACK) RDMGI = 1'b0;
      else if (TDMR) RDMGI = 1'b1;
      if (TDIN) ok = 1'b1;
    end
  endtask

  // Transaction-level model: a requester moving `words` words, an arbiter
  // granting after gdly request cycles, a memory replying after rlat cycles.
  task automatic run_burst(input int words, input bit rd, input bit wr,
                           input int gdly, input int rlat);
    bit dato;
    int done, ten, xf, exp_xf, gcnt, rcnt, t_addr, t_dat, cyc, nnxm, exp_ten;
    bit p_addr, p_sync, p_dat, p_dout, p_din, p_sack, rr_new;
    dato = !rd && wr;
    done = 0; ten = 0; xf = 0; exp_xf = 0; gcnt = 0; rcnt = 0;
    t_addr = 0; t_dat = 0; cyc = 0; nnxm = 0;
    p_addr = 0; p_sync = 0; p_dat = 0; p_dout = 0; p_din = 0; p_sack = 0; rr_new = 0;
    exp_ten = (words + MAX_XFERS - 1) / MAX_XFERS;
    dma_read_req = rd; dma_write_req = wr;
    while (!(done >= words && !TSACK) && cyc < 3000) begin
      step();
      cyc++;
      if (rr_new) chk("complete_on_rply", {dma_complete, TDIN | TDOUT}, 2'b10);
      rr_new = 1'b0;
      if (dma_complete) done++;
      if (dma_nxm) nnxm++;
      if (TSACK && !p_sack) begin
        chk("grant_not_passed", TDMGO, 0);
        exp_xf = (words - done < MAX_XFERS) ? words - done : MAX_XFERS;
        xf = 0;
      end
      if (addr_oe && !p_addr) begin
        t_addr = cyc;
        xf++;
        chk("twtbt_dir", TWTBT, dato);
      end
      if (TSYNC && !p_sync) chk("addr_setup", cyc - t_addr, ADDR_SETUP);
      if (data_oe && !p_dat) t_dat = cyc;
      if (TDIN && !p_din) chk("dati_dir", {dato, data_oe}, 2'b00);
      if (TDOUT && !p_dout) begin
        chk("dato_dir", dato, 1);
        chk("data_setup", cyc - t_dat, DATA_SETUP);
      end
      if (!TSACK && p_sack) begin
        ten++;
        chk("xfers_per_tenure", xf, exp_xf);
      end
      if (dma_complete && done >= words) begin
        dma_read_req = 1'b0; dma_write_req = 1'b0;
      end
      if (TSACK) begin
        RDMGI = 1'b0; gcnt = 0;
      end else if (TDMR) begin
        gcnt++;
        RDMGI = (gcnt > gdly);
      end else begin
        RDMGI = 1'b0;
      end
      if (TDIN || TDOUT) begin
        rcnt++;
        if (rcnt >= rlat && !RRPLY) begin
          RRPLY = 1'b1; rr_new = 1'b1;
        end
      end else begin
        RRPLY = 1'b0; rcnt = 0;
      end
      p_addr = addr_oe; p_sync = TSYNC; p_dat = data_oe;
      p_dout = TDOUT; p_din = TDIN; p_sack = TSACK;
    end
    chk("burst_in_time", (cyc < 3000), 1);
    chk("burst_words", done, words);
    chk("burst_tenures", ten, exp_ten);
    chk("burst_no_nxm", nnxm, 0);
    dma_read_req = 1'b0; dma_write_req = 1'b0; RDMGI = 1'b0; RRPLY = 1'b0;
    repeat (3) step();
    chk("burst_idle", outs(), 0);
  endtask

  initial begin
    #(50 * 200000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n, ncomp;
    reset_n = 1'b0; RINIT = 1'b0; dma_read_req = 1'b0; dma_write_req = 1'b0;
    RDMGI = 1'b0; RSYNC = 1'b0; RRPLY = 1'b0;

    // Daisy chain, held grant, bus-busy wait, address timing, RINIT mid-cycle
    vecs[0]  = '{7'b0000000, 11'b00000000000};
    vecs[1]  = '{7'b1000100, 11'b01000000000};
    vecs[2]  = '{7'b1000000, 11'b00000000000};
    vecs[3]  = '{7'b1000100, 11'b01000000000};
    vecs[4]  = '{7'b1010100, 11'b11000000000};
    vecs[5]  = '{7'b1010100, 11'b11000000000};
    vecs[6]  = '{7'b1010000, 11'b10000000000};
    vecs[7]  = '{7'b1010110, 11'b00100000000};
    vecs[8]  = '{7'b1010010, 11'b00100000000};
    vecs[9]  = '{7'b1010001, 11'b00100000000};
    vecs[10] = '{7'b1010000, 11'b00111000000};
    vecs[11] = '{7'b1010000, 11'b00111000000};
    vecs[12] = '{7'b1010000, 11'b00111000000};
    vecs[13] = '{7'b1010000, 11'b00111100000};
    vecs[14] = '{7'b1110000, 11'b00000000000};
    vecs[15] = '{7'b1000000, 11'b00000000000};

    @(negedge clk);
    for (int i = 0; i < NVEC; i++) begin
      {reset_n, RINIT, dma_read_req, dma_write_req, RDMGI, RSYNC, RRPLY} = vecs[i].in;
      step();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    do_reset(); run_burst(4, 1'b1, 1'b0, 5, 4);
    do_reset(); run_burst(6, 1'b0, 1'b1, 2, 3);
    run_burst(5, 1'b1, 1'b1, 0, 1);

    // Non-existent memory
    do_reset(); grab_din(ok);
    chk("nxm_reach_din", ok, 1);
    n = 0; ncomp = 0;
    while (!dma_nxm && n < 400) begin
      step(); n++;
      if (dma_complete) ncomp++;
    end
    chk("nxm_latency", n, NXM_TIMEOUT);
    dma_read_req = 1'b0;
    step();
    chk("nxm_strobes_drop", {TSYNC, TDIN, TSACK, dma_bus_master, addr_oe}, 0);
    chk("nxm_no_complete", ncomp + dma_complete, 0);

    // Reply first sampled on the timeout cycle
    do_reset(); grab_din(ok);
    chk("late_reach_din", ok, 1);
    repeat (NXM_TIMEOUT - 1) step();
    RRPLY = 1'b1;
    step();
    chk("late_rply_complete", {dma_complete, dma_nxm}, 2'b10);
    RRPLY = 1'b0; dma_read_req = 1'b0;
    step(); step(); step();
    chk("late_rply_release", {TSACK, dma_nxm, dma_complete}, 0);

    // Reset while TDIN is asserted, reply arriving at the same time
    do_reset(); grab_din(ok);
    chk("rst_reach_din", ok, 1);
    step(); step();
    reset_n = 1'b0; RRPLY = 1'b1;
    step();
    chk("rst_din_outputs", outs(), 0);
    reset_n = 1'b1; RRPLY = 1'b0; dma_read_req = 1'b0;
    step();
    chk("rst_din_no_pulse", outs(), 0);

    for (int r = 0; r < 8; r++) begin
      int w, sel, gd, rl;
      w   = $urandom_range(1, 9);
      sel = $urandom_range(1, 3);
      gd  = $urandom_range(0, 4);
      rl  = $urandom_range(1, 12);
      do_reset();
      run_burst(w, sel[0], sel[1], gd, rl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
